// File: rtl/sram_link_master.sv
// Host-side initiator for the byte-stream SRAM link: serialises word read/write
// requests into command/data bytes and gathers the 4-byte read response.
module sram_link_master #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        wr_done,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SEND_CMD, SEND_DATA, WAIT_RD} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic             write_q;
    logic [31:0]      wdata_q;
    logic [1:0]       idx_q;
    logic [TO_W-1:0]  timer_q;
    logic [23:0]      rbuf_q;
    logic [7:0]       tx_byte_q;
    logic             rsp_valid_q;
    logic             rsp_timeout_q;
    logic [31:0]      rsp_rdata_q;
    logic             wr_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            idx_q         <= '0;
            timer_q       <= '0;
            rbuf_q        <= '0;
            tx_byte_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            wr_done_q     <= 1'b0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wr_done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        wdata_q   <= req_wdata;
                        tx_byte_q <= {2'b00, ~req_write, req_addr};
                        state_q   <= SEND_CMD;
                    end
                end
                SEND_CMD: begin
                    if (tx_ready) begin
                        idx_q   <= '0;
                        timer_q <= '0;
                        rbuf_q  <= '0;
                        if (write_q) begin
                            // wdata_q is a shift register: its top byte is always the next to send
                            tx_byte_q <= wdata_q[31:24];
                            wdata_q   <= {wdata_q[23:0], 8'h00};
                            state_q   <= SEND_DATA;
                        end else begin
                            tx_byte_q <= '0;
                            state_q   <= WAIT_RD;
                        end
                    end
                end
                SEND_DATA: begin
                    if (tx_ready) begin
                        if (idx_q == 2'd3) begin
                            tx_byte_q <= '0;
                            wr_done_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            tx_byte_q <= wdata_q[31:24];
                            wdata_q   <= {wdata_q[23:0], 8'h00};
                            idx_q     <= idx_q + 2'd1;
                        end
                    end
                end
                WAIT_RD: begin
                    if (rx_valid) begin
                        timer_q <= '0;
                        if (idx_q == 2'd3) begin
                            rsp_rdata_q <= {rx_byte, rbuf_q};
                            rsp_valid_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            // bytes arrive LSB first, so shift them in from the top
                            rbuf_q <= {rx_byte, rbuf_q[23:8]};
                            idx_q  <= idx_q + 2'd1;
                        end
                    end else if (timer_q == TO_LAST) begin
                        rsp_rdata_q   <= '0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // req_ready is forced low while reset is asserted so every output reads 0 in reset
    assign req_ready   = (state_q == IDLE) && rst_n;
    assign tx_valid    = (state_q == SEND_CMD) || (state_q == SEND_DATA);
    assign tx_byte     = tx_byte_q;
    assign rx_ready    = (state_q == WAIT_RD);
    assign busy        = (state_q != IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign wr_done     = wr_done_q;

endmodule
